free_list: RTL and testbench
============================

Name: free_list

Overview:
- 4-wide physical-register free list for the rename stage.
- Supplies new destination PRs to up to 4 renaming instructions per cycle, which the rename table then maps.
- Reclaims the previous (stale) PR of each retiring instruction at the tail.
- Keeps a retire-time architectural head pointer so a pipeline flush restores the speculative head in one cycle.

Parameters:
- PR_NUM, 128, number of physical registers; PR index width 7.
- AR_NUM, 32, architectural registers; PRs 0..AR_NUM-1 are mapped at reset and never start in the list.
- FL_DEPTH, 128, entries in the circular buffer; power of two, >= PR_NUM-AR_NUM.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst0_dest_en..inst3_dest_en  in  1 each  instruction k needs a new PR
- inst0_dest_PR..inst3_dest_PR  out  7 each  allocated PR for instruction k; valid when its en=1 and alloc_stall=0
- alloc_stall  out  1  requested count > free_count, or flush=1
- retire0_dest_en..retire3_dest_en  in  1 each  retiring instruction k wrote a register
- retire0_old_PR..retire3_old_PR  in  7 each  stale PR released by retiring instruction k
- flush  in  1  squash all speculative allocations
- free_count  out  8  current number of free entries (tail-head)
- fl_err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Storage: FL_DEPTH x 7-bit array. head, tail and arch_head are 8-bit pointers; the low 7 bits index the array and the upper bit is the wrap bit. free_count = tail - head, modulo 256.
- Reset (async, rst_n=0):
  - entry i = AR_NUM+i for i < PR_NUM-AR_NUM; other entries = 0.
  - head = arch_head = 0; tail = PR_NUM-AR_NUM (96); free_count = 96; fl_err = 0.
  - Outputs are combinational from the reset state.
- Allocation (combinational read, registered pointer update):
  - req = popcount(inst*_dest_en).
  - Enabled instructions are compacted in order: the k-th enabled instruction (k=0..3, counting from inst0) receives entry[head+k].
  - inst_dest_PR of a disabled slot is don't-care; the bench drives it to 0.
  - alloc_stall = flush | (req > free_count). All-or-nothing: when stalled, head does not move and no PR is consumed.
  - When not stalled, head <= head + req at the clock edge.
- Release: each cycle, retire_old_PR values with en=1 are written in compacted order to entry[tail+j], and tail <= tail + rel, where rel = popcount(retire*_dest_en).
- Release is never back-pressured; PR conservation guarantees no overflow.
- arch_head <= arch_head + rel every cycle. Each retiring instruction with a destination commits exactly one allocated PR.
- Same-cycle alloc and release:
  - Both pointers update independently.
  - PRs released in cycle N are not visible to allocation until cycle N+1 (no bypass).
  - free_count in cycle N excludes them.
- Flush:
  - head <= arch_head + rel, so retires in the flush cycle are counted.
  - Allocation is blocked in that cycle; tail and release still proceed.
  - The next cycle shows the restored free_count.
- Wrap-around: pointer low bits wrap modulo FL_DEPTH. Compacted indices (head+k, tail+j) also wrap within a single cycle.
- Empty: free_count=0 -> any req>0 stalls; req=0 never stalls unless flush=1.
- Reset mid-operation: all state returns immediately to its reset values; any in-flight allocation is discarded.

Optional Feature:
- Macro FREELIST_CHECK_EN.
- Defined: fl_err sets and stays 1 until reset on any of:
  - free_count > PR_NUM-AR_NUM after an update;
  - a release of a PR < AR_NUM occurring before its first allocation;
  - retire*_dest_en=1 while arch_head == tail.
- Not defined: fl_err is tied to 0 and no checking logic is generated.

Test Plan:
- Reset, all en=1, no flush -> PRs 32,33,34,35; alloc_stall=0; next cycle free_count=92.
- Enables 1010 (inst1, inst3) -> inst1_dest_PR=32, inst3_dest_PR=33; head+=2; free_count 96->94.
- Drain to free_count=3, request 4 -> alloc_stall=1; head and free_count unchanged; request 3 next cycle -> granted, free_count=0.
- Allocate 8 (PR 32..39), retire 2 with old PRs 5,6 and flush in the same cycle -> head=arch_head=2; tail=98; free_count=96; next allocation returns PR 34 first.
- Release in cycle N while free_count=0 -> cycle N alloc_stalls; cycle N+1 allocation returns the released PR.
- With FREELIST_CHECK_EN, retire with en=1 at reset (arch_head==tail? no; force extra releases until free_count=97) -> fl_err=1 and stays 1 until rst_n=0.

Source files
------------

// File: rtl/free_list.sv
// free_list: 4-wide physical-register free list for the rename stage.
// A circular buffer of free PR indices with a speculative head (allocation),
// a tail (release of stale PRs at retire) and an architectural head that
// tracks retirement so a flush can restore the speculative head in one cycle.
// Optional consistency checking is enabled by defining FREELIST_CHECK_EN;
// without it fl_err is tied low.
module free_list #(
  parameter int PR_NUM   = 128,
  parameter int AR_NUM   = 32,
  parameter int FL_DEPTH = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inst0_dest_en,
  input  logic       inst1_dest_en,
  input  logic       inst2_dest_en,
  input  logic       inst3_dest_en,
  output logic [6:0] inst0_dest_PR,
  output logic [6:0] inst1_dest_PR,
  output logic [6:0] inst2_dest_PR,
  output logic [6:0] inst3_dest_PR,
  output logic       alloc_stall,
  input  logic       retire0_dest_en,
  input  logic       retire1_dest_en,
  input  logic       retire2_dest_en,
  input  logic       retire3_dest_en,
  input  logic [6:0] retire0_old_PR,
  input  logic [6:0] retire1_old_PR,
  input  logic [6:0] retire2_old_PR,
  input  logic [6:0] retire3_old_PR,
  input  logic       flush,
  output logic [7:0] free_count,
  output logic       fl_err
);
  localparam int IDX_W = $clog2(FL_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [6:0]       fl_mem [FL_DEPTH];
  logic [PTR_W-1:0] head_reg, tail_reg, arch_head_reg;
  logic [PTR_W-1:0] head_next, tail_next, arch_head_next;
  logic [PTR_W-1:0] free_cur;

  logic [3:0]       alloc_en, rel_en;
  logic [6:0]       old_pr    [4];
  logic [6:0]       dest_pr   [4];
  logic [2:0]       alloc_off [4];
  logic [2:0]       rel_off   [4];
  logic [IDX_W-1:0] alloc_idx [4];
  logic [IDX_W-1:0] rel_idx   [4];
  logic [2:0]       req, rel;

  assign alloc_en  = {inst3_dest_en, inst2_dest_en, inst1_dest_en, inst0_dest_en};
  assign rel_en    = {retire3_dest_en, retire2_dest_en, retire1_dest_en, retire0_dest_en};
  assign old_pr[0] = retire0_old_PR;
  assign old_pr[1] = retire1_old_PR;
  assign old_pr[2] = retire2_old_PR;
  assign old_pr[3] = retire3_old_PR;

  assign req = 3'($countones(alloc_en));
  assign rel = 3'($countones(rel_en));

  // Each slot's compacted offset is the number of enabled slots below it;
  // the index arithmetic wraps naturally in IDX_W bits.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      assign alloc_off[gi] = 3'($countones(alloc_en & 4'((1 << gi) - 1)));
      assign rel_off[gi]   = 3'($countones(rel_en & 4'((1 << gi) - 1)));
      assign alloc_idx[gi] = head_reg[IDX_W-1:0] + IDX_W'(alloc_off[gi]);
      assign rel_idx[gi]   = tail_reg[IDX_W-1:0] + IDX_W'(rel_off[gi]);
      assign dest_pr[gi]   = fl_mem[alloc_idx[gi]];
    end
  endgenerate

  assign inst0_dest_PR = dest_pr[0];
  assign inst1_dest_PR = dest_pr[1];
  assign inst2_dest_PR = dest_pr[2];
  assign inst3_dest_PR = dest_pr[3];

  // Releases this cycle are not counted: free_cur uses the registered tail.
  assign free_cur    = tail_reg - head_reg;
  assign free_count  = 8'(free_cur);
  assign alloc_stall = flush | (PTR_W'(req) > free_cur);

  // Pointer next state: release always advances tail and arch_head; head
  // either advances by the grant, holds on stall, or snaps back on flush.
  always_comb begin
    tail_next      = tail_reg + PTR_W'(rel);
    arch_head_next = arch_head_reg + PTR_W'(rel);
    if (flush)
      head_next = arch_head_next;
    else if (alloc_stall)
      head_next = head_reg;
    else
      head_next = head_reg + PTR_W'(req);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg      <= '0;
      arch_head_reg <= '0;
      tail_reg      <= PTR_W'(PR_NUM - AR_NUM);
    end else begin
      head_reg      <= head_next;
      arch_head_reg <= arch_head_next;
      tail_reg      <= tail_next;
    end
  end

  // Free-list storage: preloaded with the unmapped PRs, written at the tail
  // with released PRs in compacted order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++)
        fl_mem[i] <= (i < PR_NUM - AR_NUM) ? 7'(AR_NUM + i) : 7'd0;
    end else begin
      for (int j = 0; j < 4; j++)
        if (rel_en[j]) fl_mem[rel_idx[j]] <= old_pr[j];
    end
  end

`ifdef FREELIST_CHECK_EN
  logic             err_reg, alloc_seen_reg;
  logic [PTR_W-1:0] free_next;
  logic             low_rel, err_hit;

  // Error conditions: overfull list, release of an initial mapping before
  // anything was ever allocated, or release with nothing outstanding.
  always_comb begin
    free_next = tail_next - head_next;
    low_rel   = 1'b0;
    for (int j = 0; j < 4; j++)
      if (rel_en[j] && (old_pr[j] < 7'(AR_NUM))) low_rel = 1'b1;
    err_hit = (free_next > PTR_W'(PR_NUM - AR_NUM))
            | (low_rel & ~alloc_seen_reg)
            | ((|rel_en) & (arch_head_reg == tail_reg));
  end

  // Sticky error flag and first-allocation tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg        <= 1'b0;
      alloc_seen_reg <= 1'b0;
    end else begin
      err_reg        <= err_reg | err_hit;
      alloc_seen_reg <= alloc_seen_reg | ((req != 3'd0) & ~alloc_stall);
    end
  end

  assign fl_err = err_reg;
`else
  assign fl_err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: scoreboard bench for free_list. The driver issues one
// transaction per cycle and pushes the expected response computed from a
// queue-level model (free PRs, in-flight allocations, committed map); a
// separate monitor pops and compares at the falling edge.
module tb_free_list;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] en = '0;
  logic [3:0] ren = '0;
  logic       flush = 1'b0;
  logic [6:0] old_v  [4];
  logic [6:0] pr_out [4];
  logic       alloc_stall;
  logic [7:0] free_count;
  logic       fl_err;

  always #5 clk = ~clk;

  free_list dut (
    .clk(clk), .rst_n(rst_n),
    .inst0_dest_en(en[0]), .inst1_dest_en(en[1]),
    .inst2_dest_en(en[2]), .inst3_dest_en(en[3]),
    .inst0_dest_PR(pr_out[0]), .inst1_dest_PR(pr_out[1]),
    .inst2_dest_PR(pr_out[2]), .inst3_dest_PR(pr_out[3]),
    .alloc_stall(alloc_stall),
    .retire0_dest_en(ren[0]), .retire1_dest_en(ren[1]),
    .retire2_dest_en(ren[2]), .retire3_dest_en(ren[3]),
    .retire0_old_PR(old_v[0]), .retire1_old_PR(old_v[1]),
    .retire2_old_PR(old_v[2]), .retire3_old_PR(old_v[3]),
    .flush(flush), .free_count(free_count), .fl_err(fl_err)
  );

  typedef struct packed {
    logic [31:0]     id;
    logic [3:0]      en;
    logic            stall;
    logic [7:0]      fc;
    logic            err;
    logic [3:0][6:0] pr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   txn = 0;

  // Reference model state
  int   free_q[$];
  int   infl_pr[$];
  int   infl_ar[$];
  int   cmap[32];
  bit   alloc_seen;
  bit   exp_err;

  task automatic model_reset();
    free_q.delete();
    for (int i = 32; i < 128; i++) free_q.push_back(i);
    infl_pr.delete();
    infl_ar.delete();
    for (int i = 0; i < 32; i++) cmap[i] = i;
    alloc_seen = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic push_exp();
    exp_t x;
    int   req;
    int   k;
    req = $countones(en);
    x = '0;
    x.id = 32'(txn);
    x.en = en;
    x.fc = 8'(free_q.size());
    x.stall = flush || (req > free_q.size());
    x.err = exp_err;
    k = 0;
    for (int i = 0; i < 4; i++)
      if (en[i]) begin
        if (!x.stall) x.pr[i] = 7'(free_q[k]);
        k++;
      end
    exp_q.push_back(x);
    txn++;
  endtask

  // One cycle of stimulus. With auto_old the stale PRs are derived from the
  // committed map; otherwise old_v is used as set by the caller.
  task automatic step(input logic [3:0] e, input logic [3:0] r,
                      input logic f, input bit auto_old);
    int map_t[32];
    int idx;
    int req;
    bit stall;
    int p;
    int a;
    en = e;
    ren = r;
    flush = f;
    if (auto_old) begin
      map_t = cmap;
      idx = 0;
      for (int j = 0; j < 4; j++) begin
        if (r[j]) begin
          old_v[j] = 7'(map_t[infl_ar[idx]]);
          map_t[infl_ar[idx]] = infl_pr[idx];
          idx++;
        end else begin
          old_v[j] = 7'($urandom_range(0, 127));
        end
      end
    end
    req = $countones(e);
    stall = f || (req > free_q.size());
    push_exp();
`ifdef FREELIST_CHECK_EN
    for (int j = 0; j < 4; j++)
      if (r[j] && old_v[j] < 7'd32 && !alloc_seen) exp_err = 1'b1;
    if (r != 4'd0 && ((free_q.size() + infl_pr.size()) % 256) == 0) exp_err = 1'b1;
`endif
    for (int j = 0; j < 4; j++)
      if (r[j]) begin
        if (infl_pr.size() > 0) begin
          p = infl_pr.pop_front();
          a = infl_ar.pop_front();
          cmap[a] = p;
        end
        free_q.push_back(int'(old_v[j]));
      end
    if (f) begin
      while (infl_pr.size() > 0) begin
        free_q.push_front(infl_pr.pop_back());
        void'(infl_ar.pop_back());
      end
    end else if (!stall) begin
      for (int k = 0; k < req; k++) begin
        infl_pr.push_back(free_q.pop_front());
        infl_ar.push_back(int'($urandom_range(0, 31)));
      end
      if (req > 0) alloc_seen = 1'b1;
    end
`ifdef FREELIST_CHECK_EN
    if (free_q.size() > 96) exp_err = 1'b1;
`endif
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset held for one cycle while e is requested; the reset
  // state outputs are checked while rst_n is low.
  task automatic do_reset(input logic [3:0] e);
    en = e;
    ren = '0;
    flush = 1'b0;
    rst_n = 1'b0;
    model_reset();
    push_exp();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input int id,
                     input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s txn %0d: got %0d expected %0d", name, id, act, exp_v);
  endtask

  // Monitor: compare whatever the driver has queued for this cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("free_count", int'(x.id), 32'(free_count), 32'(x.fc));
        chk("alloc_stall", int'(x.id), 32'(alloc_stall), 32'(x.stall));
        chk("fl_err", int'(x.id), 32'(fl_err), 32'(x.err));
        for (int i = 0; i < 4; i++)
          if (x.en[i] && !x.stall)
            chk($sformatf("dest_PR%0d", i), int'(x.id), 32'(pr_out[i]), 32'(x.pr[i]));
        $display("txn %0d en=%b stall=%b free=%0d pr=%0d,%0d,%0d,%0d err=%b",
                 x.id, x.en, alloc_stall, free_count,
                 pr_out[0], pr_out[1], pr_out[2], pr_out[3], fl_err);
      end
    end
  end

  // Driver
  initial begin
    int rem;
    int rc;
    int lim;
    logic [3:0] r;
    for (int j = 0; j < 4; j++) old_v[j] = '0;
    @(posedge clk);
    #1;

    // Basic allocation and compaction
    do_reset(4'h0);
    step(4'hF, 4'h0, 1'b0, 1'b1);
    step(4'hA, 4'h0, 1'b0, 1'b1);

    // Drain to 3, stall on 4, grant 3, empty behaviour
    while (free_q.size() >= 7) step(4'hF, 4'h0, 1'b0, 1'b1);
    rem = free_q.size() - 3;
    if (rem > 0) step(4'((1 << rem) - 1), 4'h0, 1'b0, 1'b1);
    step(4'hF, 4'h0, 1'b0, 1'b1);
    step(4'h7, 4'h0, 1'b0, 1'b1);
    step(4'h0, 4'h0, 1'b0, 1'b1);
    step(4'h1, 4'h1, 1'b0, 1'b1);
    step(4'h1, 4'h0, 1'b0, 1'b1);
    step(4'h0, 4'h0, 1'b1, 1'b1);

    // Retire 5,6 with flush after allocating 8
    do_reset(4'h0);
    step(4'hF, 4'h0, 1'b0, 1'b1);
    step(4'hF, 4'h0, 1'b0, 1'b1);
    old_v[0] = 7'd5;
    old_v[1] = 7'd6;
    old_v[2] = 7'd0;
    old_v[3] = 7'd0;
    step(4'hF, 4'h3, 1'b1, 1'b0);
    step(4'h1, 4'h0, 1'b0, 1'b1);
    step(4'hF, 4'h0, 1'b0, 1'b1);

    // Randomised traffic with occasional flushes
    do_reset(4'h0);
    for (int c = 0; c < 3000; c++) begin
      lim = (infl_pr.size() < 3) ? infl_pr.size() : 3;
      rc = int'($urandom_range(0, lim));
      r = 4'h0;
      while ($countones(r) < rc) r[$urandom_range(0, 3)] = 1'b1;
      step(4'($urandom), r, ($urandom_range(0, 31) == 0), 1'b1);
    end

    // Reset in the middle of activity, then resume
    do_reset(4'hF);
    step(4'hF, 4'h0, 1'b0, 1'b1);
    step(4'h5, 4'h0, 1'b0, 1'b1);

    // Over-release from reset: flags an error when checking is built in
    do_reset(4'h0);
    old_v[0] = 7'd100;
    old_v[1] = 7'd0;
    old_v[2] = 7'd0;
    old_v[3] = 7'd0;
    step(4'h0, 4'h1, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b1);
    step(4'h3, 4'h0, 1'b0, 1'b1);
    do_reset(4'h0);
    step(4'h1, 4'h0, 1'b0, 1'b1);

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
